// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: drives the ROM address from pc and buffers {pc, word} pairs in a 2-entry FIFO for decode.
// Latency: a word fetched on one edge is presented on inst/inst_pc from the next cycle; redirect target is valid 2 cycles after redirect.
// Backpressure: with inst_ready low the FIFO fills in 2 cycles and pc holds; push and pop together at count 2 sustain full rate.
module inst_fetch_unit #(
  parameter int                 ADDR_W    = 10,
  parameter int                 DATA_W    = 10,
  parameter logic [ADDR_W-1:0]  RESET_PC  = 10'd1,
  parameter logic [DATA_W-1:0]  HALT_WORD = 10'b0010000010
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] head_pc;
  logic [DATA_W-1:0] head_word;
  logic [ADDR_W-1:0] tail_pc;
  logic [DATA_W-1:0] tail_word;
  logic [1:0]        count;
  logic              fetch_stop;
  logic              halted_q;
  logic              push;
  logic              pop;

  // Handshake decode; words left behind a delivered halt are never shown.
  always_comb begin
    inst_valid = (count != 2'd0) && !halted_q;
    pop        = inst_valid && inst_ready;
    push       = !halted_q && !fetch_stop && !redirect && ((count != 2'd2) || pop);
  end

  assign rom_address = pc;
  assign inst        = head_word;
  assign inst_pc     = head_pc;
  assign halted      = halted_q;

  // PC, FIFO and halt state; redirect flushes the buffer and overrides any push.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc         <= RESET_PC;
      head_pc    <= '0;
      head_word  <= '0;
      tail_pc    <= '0;
      tail_word  <= '0;
      count      <= 2'd0;
      fetch_stop <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      // A delivered halt wins even if a redirect arrives on the same edge:
      // decode already owns that instruction.
      if (pop && (head_word == HALT_WORD)) begin
        halted_q <= 1'b1;
      end
      if (redirect && !halted_q) begin
        count      <= 2'd0;
        pc         <= redirect_pc;
        fetch_stop <= 1'b0;
      end else begin
        if (push) begin
          pc <= pc + ADDR_W'(1);
          if (rom_data == HALT_WORD) begin
            fetch_stop <= 1'b1;
          end
        end
        case ({push, pop})
          2'b10: begin
            if (count == 2'd0) begin
              head_pc   <= pc;
              head_word <= rom_data;
            end else begin
              tail_pc   <= pc;
              tail_word <= rom_data;
            end
            count <= count + 2'd1;
          end
          2'b01: begin
            if (count == 2'd2) begin
              head_pc   <= tail_pc;
              head_word <= tail_word;
            end
            count <= count - 2'd1;
          end
          2'b11: begin
            if (count == 2'd2) begin
              head_pc   <= tail_pc;
              head_word <= tail_word;
              tail_pc   <= pc;
              tail_word <= rom_data;
            end else begin
              head_pc   <= pc;
              head_word <= rom_data;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

  logic       clk;
  logic       reset;
  logic [9:0] rom_address;
  logic [9:0] rom_data;
  logic       inst_valid;
  logic       inst_ready;
  logic [9:0] inst;
  logic [9:0] inst_pc;
  logic       redirect;
  logic [9:0] redirect_pc;
  logic       halted;

  logic [9:0] rom [0:1023];
  int checks;
  int errors;

  inst_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .rom_address (rom_address),
    .rom_data    (rom_data),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halted      (halted)
  );

  // Combinational ROM, same-cycle read.
  assign rom_data = rom[rom_address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    // Non-program words all have bit 8 set so none alias the halt encoding.
    for (int i = 0; i < 1024; i++) rom[i] = 10'h100 | 10'(i & 8'hFF);
    rom[1]  = 10'h334;
    rom[2]  = 10'h33D;
    rom[17] = 10'b0010000010;

    reset = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 10'd0;
    step(); step();
    check_val("rst_addr",   32'(rom_address), 32'd1);
    check_val("rst_valid",  32'(inst_valid),  32'd0);
    check_val("rst_inst",   32'(inst),        32'd0);
    check_val("rst_pc",     32'(inst_pc),     32'd0);
    check_val("rst_halted", 32'(halted),      32'd0);

    // Backpressure from the first valid cycle.
    reset = 1'b1;
    step();
    check_val("first_valid", 32'(inst_valid),  32'd1);
    check_val("first_pc",    32'(inst_pc),     32'd1);
    check_val("first_word",  32'(inst),        32'h334);
    check_val("first_addr",  32'(rom_address), 32'd2);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("bp_pc",   32'(inst_pc),     32'd1);
      check_val("bp_word", 32'(inst),        32'h334);
      check_val("bp_addr", 32'(rom_address), 32'd3);
    end

    // Release: 1, 2, 3, ... one per cycle.
    inst_ready = 1'b1;
    check_val("strm_pc1", 32'(inst_pc), 32'd1);
    step();
    check_val("strm_pc2",   32'(inst_pc), 32'd2);
    check_val("strm_word2", 32'(inst),    32'h33D);
    for (int p = 3; p <= 6; p++) begin
      step();
      check_val("strm_valid", 32'(inst_valid), 32'd1);
      check_val("strm_pc",    32'(inst_pc),    32'(p));
    end

    // Fill, then redirect to 4 while full.
    inst_ready = 1'b0;
    step(); step();
    redirect = 1'b1; redirect_pc = 10'd4;
    step();
    redirect = 1'b0;
    check_val("redir_valid", 32'(inst_valid),  32'd0);
    check_val("redir_addr",  32'(rom_address), 32'd4);
    inst_ready = 1'b1;
    step();
    check_val("redir_tgt_valid", 32'(inst_valid), 32'd1);
    check_val("redir_tgt_pc",    32'(inst_pc),    32'd4);

    // Speculative halt: fetch the halt word, redirect before it is popped.
    inst_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 10'd16;
    step();
    redirect = 1'b0;
    step(); step(); step();
    check_val("spec_stop_addr", 32'(rom_address), 32'd18);
    check_val("spec_head_pc",   32'(inst_pc),     32'd16);
    redirect = 1'b1; redirect_pc = 10'd4;
    step();
    redirect = 1'b0;
    check_val("spec_halted", 32'(halted),      32'd0);
    check_val("spec_addr",   32'(rom_address), 32'd4);
    inst_ready = 1'b1;
    step();
    check_val("spec_resume_pc", 32'(inst_pc), 32'd4);

    // Real halt: stream 4..17.
    for (int p = 4; p <= 17; p++) begin
      check_val("halt_strm_valid", 32'(inst_valid), 32'd1);
      check_val("halt_strm_pc",    32'(inst_pc),    32'(p));
      check_val("halt_strm_hlt",   32'(halted),     32'd0);
      if (p == 17) check_val("halt_word", 32'(inst), 32'h082);
      step();
    end
    check_val("halt_set",   32'(halted),      32'd1);
    check_val("halt_valid", 32'(inst_valid),  32'd0);
    check_val("halt_addr",  32'(rom_address), 32'd18);
    redirect = 1'b1; redirect_pc = 10'd4;
    step();
    redirect = 1'b0;
    step();
    check_val("halt_redir_addr",  32'(rom_address), 32'd18);
    check_val("halt_redir_hlt",   32'(halted),      32'd1);
    check_val("halt_redir_valid", 32'(inst_valid),  32'd0);

    // Reset clears halt; then wrap at 1023.
    reset = 1'b0;
    step();
    check_val("rst2_halted", 32'(halted),      32'd0);
    check_val("rst2_addr",   32'(rom_address), 32'd1);
    reset = 1'b1; inst_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 10'd1023;
    step();
    redirect = 1'b0;
    check_val("wrap_addr", 32'(rom_address), 32'd1023);
    inst_ready = 1'b1;
    step();
    check_val("wrap_pc1023", 32'(inst_pc), 32'd1023);
    check_val("wrap_w1023",  32'(inst),    32'h1FF);
    step();
    check_val("wrap_pc0",   32'(inst_pc),     32'd0);
    check_val("wrap_w0",    32'(inst),        32'h100);
    check_val("wrap_addr1", 32'(rom_address), 32'd1);

    // Mid-stream reset with the FIFO full.
    inst_ready = 1'b0;
    step(); step();
    check_val("full_addr",  32'(rom_address), 32'd2);
    check_val("full_valid", 32'(inst_valid),  32'd1);
    reset = 1'b0;
    step();
    check_val("mid_rst_valid", 32'(inst_valid),  32'd0);
    check_val("mid_rst_addr",  32'(rom_address), 32'd1);
    check_val("mid_rst_pc",    32'(inst_pc),     32'd0);
    reset = 1'b1; inst_ready = 1'b1;
    step();
    check_val("post_rst_valid", 32'(inst_valid), 32'd1);
    check_val("post_rst_pc",    32'(inst_pc),    32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
